// File: rtl/serial_display_pkg.sv
// Shared constants and decode helpers for the multi-digit serial hex display.
package serial_display_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_C     = 8'h39;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_F     = 8'h71;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_ESC = 8'h1B;
  localparam logic [7:0] ASC_DOT = 8'h2E;

  // Returns {valid, nibble}; valid is clear for any non-hex byte.
  function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  function automatic logic [7:0] nibble_to_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit scan timebase: prescaler of REFRESH_DIV cycles stepping a wrapping digit index.
module seg_scan_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          advance
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    advance = (pre_q == PRE_W'(REFRESH_DIV - 1));
    pre_d   = pre_q + 1'b1;
    idx_d   = idx_q;
    if (advance) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/serial_display_mux.sv
// Multi-digit UART hex display: digit buffer with edit commands, scanned onto a 7-seg bank.
// Define SERIAL_DISPLAY_DP_EN to store and display per-digit decimal points.
module serial_display_mux
  import serial_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic [7:0]                        ascii_data,
  input  logic                              data_valid,
  output logic [7:0]                        seven_segment_data,
  output logic [NUM_DIGITS-1:0]             seven_segment_enable,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [IDX_W-1:0]                scan_idx;
  logic                            scan_adv;
  logic [NUM_DIGITS-1:0][3:0]      nib_q, nib_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [7:0]                      seg_q, seg_d;
  logic [NUM_DIGITS-1:0]           en_q, en_d;
  logic                            adv_q;
  logic [4:0]                      dec;
`ifdef SERIAL_DISPLAY_DP_EN
  logic [NUM_DIGITS-1:0]           dp_q, dp_d;
`endif

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_timer (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .idx    (scan_idx),
    .advance(scan_adv)
  );

  // Digits at index >= cnt_q are blank; valid digits are always packed from digit 0 up.
  always_comb begin
    nib_d = nib_q;
    cnt_d = cnt_q;
    dec   = ascii_to_nibble(ascii_data);
`ifdef SERIAL_DISPLAY_DP_EN
    dp_d  = dp_q;
`endif
    if (data_valid) begin
      if (dec[4]) begin
        nib_d = {nib_q[NUM_DIGITS-2:0], dec[3:0]};
        if (cnt_q != CNT_W'(NUM_DIGITS)) cnt_d = cnt_q + 1'b1;
`ifdef SERIAL_DISPLAY_DP_EN
        dp_d = {dp_q[NUM_DIGITS-2:0], 1'b0};
`endif
      end else if (ascii_data == ASC_BS) begin
        if (cnt_q != '0) begin
          nib_d = {4'h0, nib_q[NUM_DIGITS-1:1]};
          cnt_d = cnt_q - 1'b1;
`ifdef SERIAL_DISPLAY_DP_EN
          dp_d = {1'b0, dp_q[NUM_DIGITS-1:1]};
`endif
        end
      end else if (ascii_data == ASC_CR || ascii_data == ASC_ESC) begin
        cnt_d = '0;
`ifdef SERIAL_DISPLAY_DP_EN
        dp_d = '0;
`endif
      end
`ifdef SERIAL_DISPLAY_DP_EN
      else if (ascii_data == ASC_DOT && cnt_q != '0) begin
        dp_d[0] = 1'b1;
      end
`endif
    end
  end

  // Enables reload only when the index has just moved, or on the first edge out of reset.
  always_comb begin
    seg_d = SEG_BLANK;
    if (CNT_W'(scan_idx) < cnt_q) begin
      seg_d = nibble_to_seg(nib_q[scan_idx]);
`ifdef SERIAL_DISPLAY_DP_EN
      seg_d[7] = dp_q[scan_idx];
`endif
    end
    en_d = en_q;
    if (adv_q || (&en_q)) en_d = ~(NUM_DIGITS'(1) << scan_idx);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      nib_q <= '0;
      cnt_q <= '0;
      seg_q <= '0;
      en_q  <= '1;
      adv_q <= 1'b0;
`ifdef SERIAL_DISPLAY_DP_EN
      dp_q  <= '0;
`endif
    end else begin
      nib_q <= nib_d;
      cnt_q <= cnt_d;
      seg_q <= seg_d;
      en_q  <= en_d;
      adv_q <= scan_adv;
`ifdef SERIAL_DISPLAY_DP_EN
      dp_q  <= dp_d;
`endif
    end
  end

  assign seven_segment_data   = seg_q;
  assign seven_segment_enable = en_q;
  assign digit_count          = cnt_q;

endmodule

// File: tb/tb_serial_display_mux.sv
// Self-checking bench for serial_display_mux (NUM_DIGITS=4, REFRESH_DIV=4) against a queue model.
module tb_serial_display_mux;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    ascii_data = 8'h00;
  logic          data_valid = 1'b0;
  logic [7:0]    seven_segment_data;
  logic [ND-1:0] seven_segment_enable;
  logic [2:0]    digit_count;

  always #5 clk_in = ~clk_in;

  serial_display_mux #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk_in              (clk_in),
    .rst_n               (rst_n),
    .ascii_data          (ascii_data),
    .data_valid          (data_valid),
    .seven_segment_data  (seven_segment_data),
    .seven_segment_enable(seven_segment_enable),
    .digit_count         (digit_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mq[$];      // model buffer, oldest first; bit4 = dp flag
  int k = 0;      // clock edges since reset release

  byte unsigned seg_tab[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  typedef struct {
    byte unsigned ch;
    int           cnt;
    int           d0;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  function automatic int exp_code(input int i);
    int v;
    if (i >= mq.size()) return 0;
    v = mq[mq.size() - 1 - i];
    return seg_tab[v & 15] | (((v >> 4) & 1) != 0 ? 8'h80 : 8'h00);
  endfunction

  task automatic model_apply();
    int b;
    if (!data_valid) return;
    b = ascii_data;
    if (b >= 48 && b <= 57 || b >= 65 && b <= 70 || b >= 97 && b <= 102) begin
      mq.push_back(b <= 57 ? b - 48 : (b <= 70 ? b - 55 : b - 87));
      if (mq.size() > ND) void'(mq.pop_front());
    end else if (b == 8) begin
      if (mq.size() > 0) void'(mq.pop_back());
    end else if (b == 13 || b == 27) begin
      mq.delete();
    end
`ifdef SERIAL_DISPLAY_DP_EN
    else if (b == 46 && mq.size() > 0) begin
      mq[mq.size() - 1] = mq[mq.size() - 1] | 16;
    end
`endif
  endtask

  // One clock edge: outputs reflect pre-edge model state; count reflects post-edge state.
  task automatic step();
    int idx, e_en, e_d;
    @(posedge clk_in);
    idx  = (k / RD) % ND;
    e_en = (~(1 << idx)) & 4'hF;
    e_d  = exp_code(idx);
    model_apply();
    k++;
    #1;
    check("enable", 32'(seven_segment_enable), 32'(e_en));
    check("data", 32'(seven_segment_data), 32'(e_d));
    check("count", 32'(digit_count), 32'(mq.size()));
  endtask

  task automatic send(input byte unsigned b);
    ascii_data = b;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  task automatic wait_digit(input int i);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (seven_segment_enable == 4'((~(1 << i)) & 4'hF)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_digit%0d: enable %b never selected digit within 24 cycles", i,
               seven_segment_enable);
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_enable", 32'(seven_segment_enable), 32'hF);
    check("rst_data", 32'(seven_segment_data), 32'h0);
    check("rst_count", 32'(digit_count), 32'h0);
    mq.delete();
    k = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("rst_hold_enable", 32'(seven_segment_enable), 32'hF);
    rst_n = 1'b1;
  endtask

  initial begin
    int fd[4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};
    byte unsigned pool[12] = '{8'h30, 8'h39, 8'h41, 8'h46, 8'h61, 8'h66, 8'h08, 8'h0D,
                               8'h1B, 8'h2E, 8'h47, 8'h35};

    tbl[0]  = '{8'h31, 1, 8'h06};
    tbl[1]  = '{8'h32, 2, 8'h5B};
    tbl[2]  = '{8'h33, 3, 8'h4F};
    tbl[3]  = '{8'h34, 4, 8'h66};
    tbl[4]  = '{8'h61, 4, 8'h77};
    tbl[5]  = '{8'h47, 4, 8'h77};
    tbl[6]  = '{8'h0D, 0, 8'h00};
    tbl[7]  = '{8'h31, 1, 8'h06};
    tbl[8]  = '{8'h32, 2, 8'h5B};
    tbl[9]  = '{8'h08, 1, 8'h06};
    tbl[10] = '{8'h08, 0, 8'h00};
    tbl[11] = '{8'h08, 0, 8'h00};
    tbl[12] = '{8'h35, 1, 8'h6D};
    tbl[13] = '{8'h1B, 0, 8'h00};
    tbl[14] = '{8'h37, 1, 8'h07};
`ifdef SERIAL_DISPLAY_DP_EN
    tbl[15] = '{8'h2E, 1, 8'h87};
`else
    tbl[15] = '{8'h2E, 1, 8'h07};
`endif
    tbl[16] = '{8'h46, 2, 8'h71};

    // Power-up reset, then a short idle scan.
    #12;
    check("por_enable", 32'(seven_segment_enable), 32'hF);
    check("por_count", 32'(digit_count), 32'h0);
    @(negedge clk_in);
    rst_n = 1'b1;
    step();
    check("first_enable", 32'(seven_segment_enable), 32'hE);
    repeat (6) step();

    // Table of single-byte edits, each checked when digit 0 is next scanned.
    foreach (tbl[i]) begin
      send(tbl[i].ch);
      step();
      wait_digit(0);
      check($sformatf("tbl%0d_d0", i), 32'(seven_segment_data), 32'(tbl[i].d0));
      check($sformatf("tbl%0d_cnt", i), 32'(digit_count), 32'(tbl[i].cnt));
    end

    // "1234" shown across a full scan.
    send(8'h0D);
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    step();
    for (int i = 0; i < ND; i++) begin
      wait_digit(i);
      check($sformatf("full_d%0d", i), 32'(seven_segment_data), 32'(fd[i]));
    end
    check("full_cnt", 32'(digit_count), 32'd4);

    // Reset asserted mid-scan with a loaded buffer.
    step(); step();
    do_reset();
    for (int j = 1; j <= 17; j++) begin
      step();
      check($sformatf("scan_e%0d", j), 32'(seven_segment_enable),
            32'((~(1 << (((j - 1) / RD) % ND))) & 4'hF));
    end

    // Byte sampled on the edge where the index wraps to digit 0.
    for (int c = 0; c < 32 && ((k + 1) % (RD * ND)) != 0; c++) step();
    send(8'h39);
    step();
    check("adv_enable", 32'(seven_segment_enable), 32'hE);
    check("adv_data", 32'(seven_segment_data), 32'h6F);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        ascii_data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
        data_valid = 1'b1;
      end else begin
        ascii_data = 8'($urandom);
        data_valid = 1'b0;
      end
      step();
    end
    data_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
